// File: rtl/esfa_op_sequencer.sv
// Command sequencer for the ESFA cell array: expands one array operation
// into a fixed micro-op sequence on the cell broadcast bus and returns one result.
module esfa_op_sequencer #(
    parameter int         DW      = 8,
    parameter logic [7:0] NOP_SEL = 8'd7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_handle,
    input  logic [DW-1:0] cmd_index,
    input  logic [DW-1:0] cmd_value,
    input  logic [DW-1:0] cmd_meta,
    input  logic          cmd_is_meta,
    output logic [7:0]    cell_sel,
    output logic          cell_we,
    output logic [DW-1:0] cell_handle,
    output logic [DW-1:0] cell_index,
    output logic [DW-1:0] cell_value,
    output logic [DW-1:0] cell_meta,
    output logic          cell_is_meta,
    input  logic          arr_bool,
    input  logic [DW-1:0] arr_value,
    input  logic [DW-1:0] arr_context,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_bool,
    output logic [DW-1:0] rsp_value,
    output logic [DW-1:0] rsp_context,
    output logic          rsp_error,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SAMPLE,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [2:0]    op_q, op_d;
    logic [7:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [DW-1:0] handle_q, handle_d;
    logic [DW-1:0] index_q, index_d;
    logic [DW-1:0] value_q, value_d;
    logic [DW-1:0] meta_q, meta_d;
    logic          is_meta_q, is_meta_d;
    logic          rvalid_q, rvalid_d;
    logic          rbool_q, rbool_d;
    logic [DW-1:0] rvalue_q, rvalue_d;
    logic [DW-1:0] rctx_q, rctx_d;
    logic          rerr_q, rerr_d;

    // Micro-op code for a given step of a legal operation.
    function automatic logic [7:0] step_code(input logic [2:0] op,
                                             input logic [1:0] step);
        logic [7:0] c;
        c = NOP_SEL;
        case (op)
            3'd0: c = 8'd1;
            3'd1: begin
                case (step)
                    2'd0:    c = 8'd5;
                    2'd1:    c = 8'd0;
                    default: c = 8'd6;
                endcase
            end
            3'd2: c = 8'd2;
            3'd3: c = (step == 2'd0) ? 8'd3 : 8'd4;
            default: c = NOP_SEL;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] last_step(input logic [2:0] op);
        logic [1:0] s;
        case (op)
            3'd1:    s = 2'd2;
            3'd3:    s = 2'd1;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] report_step(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic step_we(input logic [2:0] op);
        return (op != 3'd0);
    endfunction

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        op_d      = op_q;
        sel_d     = NOP_SEL;
        we_d      = 1'b0;
        handle_d  = handle_q;
        index_d   = index_q;
        value_d   = value_q;
        meta_d    = meta_q;
        is_meta_d = is_meta_q;
        rvalid_d  = 1'b0;
        rbool_d   = rbool_q;
        rvalue_d  = rvalue_q;
        rctx_d    = rctx_q;
        rerr_d    = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    handle_d  = cmd_handle;
                    index_d   = cmd_index;
                    value_d   = cmd_value;
                    meta_d    = cmd_meta;
                    is_meta_d = cmd_is_meta;
                    op_d      = cmd_op;
                    step_d    = 2'd0;
                    if (cmd_op[2]) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rbool_d  = 1'b0;
                        rvalue_d = '0;
                        rctx_d   = '0;
                    end else begin
                        state_d = S_ISSUE;
                        sel_d   = step_code(cmd_op, 2'd0);
                        we_d    = step_we(cmd_op);
                        rerr_d  = 1'b0;
                    end
                end
            end
            S_ISSUE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                // arr_* reflects the micro-op issued in the previous cycle
                if (step_q == report_step(op_q)) begin
                    rbool_d  = arr_bool;
                    rvalue_d = arr_value;
                    rctx_d   = arr_context;
                end
                if (step_q == last_step(op_q)) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    step_d  = step_q + 2'd1;
                    sel_d   = step_code(op_q, step_q + 2'd1);
                    we_d    = step_we(op_q);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
                else rvalid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            op_q      <= 3'd0;
            sel_q     <= NOP_SEL;
            we_q      <= 1'b0;
            handle_q  <= '0;
            index_q   <= '0;
            value_q   <= '0;
            meta_q    <= '0;
            is_meta_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rbool_q   <= 1'b0;
            rvalue_q  <= '0;
            rctx_q    <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            handle_q  <= handle_d;
            index_q   <= index_d;
            value_q   <= value_d;
            meta_q    <= meta_d;
            is_meta_q <= is_meta_d;
            rvalid_q  <= rvalid_d;
            rbool_q   <= rbool_d;
            rvalue_q  <= rvalue_d;
            rctx_q    <= rctx_d;
            rerr_q    <= rerr_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign cell_sel     = sel_q;
    assign cell_we      = we_q;
    assign cell_handle  = handle_q;
    assign cell_index   = index_q;
    assign cell_value   = value_q;
    assign cell_meta    = meta_q;
    assign cell_is_meta = is_meta_q;
    assign rsp_valid    = rvalid_q;
    assign rsp_bool     = rbool_q;
    assign rsp_value    = rvalue_q;
    assign rsp_context  = rctx_q;
    assign rsp_error    = rerr_q;

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Bench for esfa_op_sequencer: registered cell-array stand-in,
// directed commands, scoreboard checked by a response monitor.
module tb_esfa_op_sequencer;

    localparam int DW = 8;

    typedef struct packed {
        logic          b;
        logic [DW-1:0] v;
        logic [DW-1:0] c;
        logic          e;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_handle, cmd_index, cmd_value, cmd_meta;
    logic          cmd_is_meta;
    logic [7:0]    cell_sel;
    logic          cell_we;
    logic [DW-1:0] cell_handle, cell_index, cell_value, cell_meta;
    logic          cell_is_meta;
    logic          arr_bool = 1'b0;
    logic [DW-1:0] arr_value = '0;
    logic [DW-1:0] arr_context = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_bool;
    logic [DW-1:0] rsp_value, rsp_context;
    logic          rsp_error;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    rsp_t sb[$];

    esfa_op_sequencer #(.DW(DW), .NOP_SEL(8'd7)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_handle(cmd_handle), .cmd_index(cmd_index),
        .cmd_value(cmd_value), .cmd_meta(cmd_meta),
        .cmd_is_meta(cmd_is_meta),
        .cell_sel(cell_sel), .cell_we(cell_we),
        .cell_handle(cell_handle), .cell_index(cell_index),
        .cell_value(cell_value), .cell_meta(cell_meta),
        .cell_is_meta(cell_is_meta),
        .arr_bool(arr_bool), .arr_value(arr_value),
        .arr_context(arr_context),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_bool(rsp_bool), .rsp_value(rsp_value),
        .rsp_context(rsp_context), .rsp_error(rsp_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered array stand-in; NOP parks outputs on a junk pattern.
    always @(posedge clk) begin
        case (cell_sel)
            8'd1:    begin arr_bool <= 1'b1; arr_value <= 8'h2A; arr_context <= 8'h10; end
            8'd5:    begin arr_bool <= 1'b1; arr_value <= 8'h55; arr_context <= 8'h01; end
            8'd0:    begin arr_bool <= 1'b0; arr_value <= 8'h11; arr_context <= 8'h22; end
            8'd6:    begin arr_bool <= 1'b1; arr_value <= 8'hFF; arr_context <= 8'h33; end
            8'd2:    begin arr_bool <= 1'b1; arr_value <= 8'h44; arr_context <= 8'h05; end
            8'd3:    begin arr_bool <= 1'b0; arr_value <= 8'h66; arr_context <= 8'h06; end
            8'd4:    begin arr_bool <= 1'b1; arr_value <= 8'h77; arr_context <= 8'h08; end
            default: begin arr_bool <= 1'b1; arr_value <= 8'hEE; arr_context <= 8'hEE; end
        endcase
    end

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_bool", rsp_bool, e.b);
                chk("rsp_value", rsp_value, e.v);
                chk("rsp_context", rsp_context, e.c);
                chk("rsp_error", rsp_error, e.e);
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op,
                           input logic [7:0] h, ix, v, m,
                           input logic im, input int n,
                           input logic [23:0] codes, input logic wexp,
                           input rsp_t exp, input int hold);
        int lat;
        logic [7:0] s;
        sb.push_back(exp);
        @(posedge clk); #1;
        cmd_op = op; cmd_handle = h; cmd_index = ix;
        cmd_value = v; cmd_meta = m; cmd_is_meta = im;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("cmd_ready_at_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_handle = 8'hA5; cmd_index = 8'hA5;
        cmd_value = 8'hA5; cmd_meta = 8'hA5; cmd_is_meta = ~im;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (k <= 2 * n) begin
                if (k % 2 == 1) begin
                    s = codes[8*((k-1)/2) +: 8];
                    chk("issue_sel", cell_sel, s);
                    chk("issue_we", cell_we, wexp);
                end else begin
                    chk("sample_sel", cell_sel, 8'd7);
                    chk("sample_we", cell_we, 0);
                end
            end
        end
        chk("latency", lat, 2 * n + 1);
        chk("resp_bus_parked", {cell_sel, cell_we}, {8'd7, 1'b0});
        chk("operands_held",
            {cell_handle, cell_index, cell_value, cell_meta, cell_is_meta},
            {h, ix, v, m, im});
        chk("busy_in_resp", busy, 1);
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp_stable",
                {rsp_bool, rsp_value, rsp_context, rsp_error}, exp);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", {cmd_ready, rsp_valid, busy}, 3'b100);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
        cmd_handle = '0; cmd_index = '0; cmd_value = '0; cmd_meta = '0;
        cmd_is_meta = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {cell_sel, cell_we, cell_handle, cell_index, cell_value,
             cell_meta, cell_is_meta},
            {8'd7, 1'b0, 33'd0});
        chk("reset_rsp",
            {rsp_valid, rsp_bool, rsp_value, rsp_context, rsp_error, busy},
            20'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", {cell_sel, cell_we, cmd_ready, rsp_valid},
                {8'd7, 1'b0, 1'b1, 1'b0});
        end

        // lookup
        run_cmd(3'd0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 1,
                24'h000001, 1'b0, {1'b1, 8'h2A, 8'h10, 1'b0}, 0);
        // update: report is the SAMPLE after sel 0, not after enrank
        run_cmd(3'd1, 8'h01, 8'h02, 8'h7F, 8'h00, 1'b0, 3,
                24'h060005, 1'b1, {1'b0, 8'h11, 8'h22, 1'b0}, 0);
        // encode in metadata mode
        run_cmd(3'd2, 8'h04, 8'h06, 8'h12, 8'h3C, 1'b1, 1,
                24'h000002, 1'b1, {1'b1, 8'h44, 8'h05, 1'b0}, 0);
        // congrue with back-pressure
        run_cmd(3'd3, 8'h07, 8'h08, 8'h09, 8'h0A, 1'b0, 2,
                24'h000403, 1'b1, {1'b1, 8'h77, 8'h08, 1'b0}, 5);
        // illegal opcodes
        run_cmd(3'd6, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 1'b0, 0,
                24'h000000, 1'b0, {1'b0, 8'h00, 8'h00, 1'b1}, 0);
        run_cmd(3'd4, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 0,
                24'h000000, 1'b0, {1'b0, 8'h00, 8'h00, 1'b1}, 2);

        // reset during the sel=0 issue of an update
        @(posedge clk); #1;
        cmd_op = 3'd1; cmd_handle = 8'h01; cmd_index = 8'h02;
        cmd_value = 8'h7F; cmd_meta = 8'h00; cmd_is_meta = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_sel", cell_sel, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_bus", {cell_sel, cell_we, cell_handle, cell_value},
            {8'd7, 1'b0, 16'd0});
        chk("mid_reset_ctrl", {busy, rsp_valid, cmd_ready}, 3'b001);

        run_cmd(3'd0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 1,
                24'h000001, 1'b0, {1'b1, 8'h2A, 8'h10, 1'b0}, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/esfa_op_sequencer.md
Name: esfa_op_sequencer

Overview:
- Upstream command stage for the ESFA memory-cell array. Accepts one high-level array operation at a time and expands it into a fixed sequence of cell micro-ops on the broadcast bus (selector, willWrite, handle, index, value, metadata).
- Captures the array's registered reduced response and returns one result per command over a valid/ready handshake.
- Between commands the bus is parked on a no-op selector, so cells never act spuriously.

Parameters:
- DW, 8, width of handle/index/value/metadata/context buses.
- NOP_SEL, 7, selector value that matches no cell combinator (idle code).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_op  in  3  0 lookup, 1 update, 2 encode, 3 congrue; 4-7 illegal.
- cmd_handle, cmd_index, cmd_value, cmd_meta  in  DW each  operands.
- cmd_is_meta  in  1  metadata-mode flag.
- cell_sel  out  8  broadcast selector to all cells.
- cell_we  out  1  broadcast willWrite.
- cell_handle, cell_index, cell_value, cell_meta  out  DW each  broadcast operands.
- cell_is_meta  out  1  broadcast isMetadata.
- arr_bool  in  1  OR of all cell new_bool outputs.
- arr_value, arr_context  in  DW  value/context from the winning cell (externally reduced).
- rsp_valid  out  1  result present.
- rsp_ready  in  1  result consumed.
- rsp_bool, rsp_value, rsp_context  out  1/DW/DW  captured result.
- rsp_error  out  1  illegal opcode.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Micro-op codes on cell_sel: 0 update, 1 lookUp, 2 encode, 3 congrueUp, 4 congrueDown, 5 markAvailableCell, 6 enrank.
- Step lists, with the report step marked *:
  - lookup: 1*/we=0.
  - update: 5/we=1, 0*/we=1, 6/we=1.
  - encode: 2*/we=1.
  - congrue: 3/we=1, 4*/we=1.
- Reset: state IDLE, step counter 0; cell_sel=NOP_SEL; cell_we=0; all cell_* operands 0; rsp_valid=0, rsp_bool=0, rsp_value=0, rsp_context=0, rsp_error=0; busy=0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch the operands and op, and set step=0. A legal op goes to ISSUE; an illegal op goes to RESP with rsp_error=1 and rsp_bool/value/context=0.
  - ISSUE (1 cycle): cell_sel=step code, cell_we=step we, operands driven from the latches. Go to SAMPLE.
  - SAMPLE (1 cycle): cell_sel=NOP_SEL, cell_we=0. The cells registered their outputs at the ISSUE->SAMPLE edge, so arr_* are valid during SAMPLE.
    - If the step is the report step, capture arr_* into rsp_* at the end of SAMPLE.
    - If this is the last step, go to RESP; otherwise step+1 and go to ISSUE.
  - RESP: rsp_valid=1 with rsp_* held stable. Return to IDLE on the cycle rsp_ready=1. If rsp_ready is low, hold indefinitely with the bus parked.
- Latency, with acceptance at cycle 0: rsp_valid first asserts at cycle 2*N+1 for an N-step op, i.e. lookup/encode 3, congrue 5, update 7. An illegal op asserts rsp_valid at cycle 1.
- Operand buses hold their latched values for the whole command, including SAMPLE and RESP. They change only on acceptance.
- cmd_ready is 0 in RESP, so there is no accept/respond overlap. Simultaneous rsp_ready and a new cmd_valid: the response completes that cycle and the command is accepted in the following IDLE cycle.
- rsp_error=0 for all legal ops.
- Reset mid-command: immediately returns to the reset values above. Cell contents are not rolled back, so a partially executed update may remain; software reissues the command.
- cell_sel/cell_we are registered outputs and never glitch to a non-NOP code outside ISSUE.

Test Plan:
- Reset then idle 10 cycles -> cell_sel=7, cell_we=0, cmd_ready=1, rsp_valid=0 throughout.
- Lookup handle=0x03 index=0x05, arr_bool=1 and arr_value=0x2A during SAMPLE -> exactly one ISSUE cycle with sel=1, we=0. rsp_valid at cycle 3 with rsp_bool=1, rsp_value=0x2A, rsp_error=0.
- Update handle=0x01 index=0x02 value=0x7F -> sel sequence 5,7,0,7,6,7 with we=1 on each ISSUE. rsp_bool/value equal the arr_* presented in the SAMPLE after sel=0 (0/0x11 presented there, 1/0xFF after enrank). rsp_valid at cycle 7 with rsp_bool=0, rsp_value=0x11.
- Congrue with rsp_ready held low for 5 cycles -> rsp_valid stays 1 and rsp_* stable, cmd_ready=0. Then rsp_ready=1 for one cycle -> return to IDLE, and the next command is accepted one cycle later.
- cmd_op=6 -> no ISSUE cycle (cell_sel stays 7). rsp_valid at cycle 1 with rsp_error=1, rsp_bool=0, rsp_value=0.
- reset asserted in update step 2 (the ISSUE of sel=0) -> next cycle cell_sel=7, cell_we=0, busy=0, rsp_valid=0, cmd_ready=1. A following lookup completes normally.
